// File: rtl/flash_addr_ctrl.sv
// flash_addr_ctrl: walks a word address through an audio region of flash and
// issues one Avalon-MM read per address. The sample-clock domain requests each
// step with get_new_address.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | paused or stopped, no read outstanding, address retained
// ISSUE      | read strobe asserted, waiting for waitrequest to drop
// WAIT_VALID | command accepted, waiting for readdatavalid
// HOLD       | data valid for the consumer, waiting for the next advance
//
// Ports
//   clk                      system clock, rising edge
//   reset                    synchronous active-high reset
//   start                    level, 1 = playback enabled
//   restart                  pulse, jump to the region start for the direction
//   count_up                 direction, 1 = increment, 0 = decrement
//   get_new_address          advance request, asynchronous to clk
//   flash_mem_waitrequest    Avalon-MM waitrequest
//   flash_mem_readdatavalid  Avalon-MM readdatavalid
//   flash_mem_read           Avalon-MM read strobe
//   flash_mem_address        current word address
//   flash_mem_byteenable     constant 4'hF
//   read_flash_en            flash readdata valid for the consumer
module flash_addr_ctrl #(
    parameter logic [22:0] START_ADDR = 23'h000000,
    parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        restart,
    input  logic        count_up,
    input  logic        get_new_address,
    input  logic        flash_mem_waitrequest,
    input  logic        flash_mem_readdatavalid,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic [3:0]  flash_mem_byteenable,
    output logic        read_flash_en
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_VALID = 2'd2,
        HOLD       = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_gna_meta;
    logic        r_gna_sync;
    logic        r_gna_prev;
    logic        r_rst_pend;
    logic        r_read;
    logic        r_ren;
    logic [22:0] r_addr;

    logic        w_adv;
    logic        w_rst_any;
    logic [22:0] w_addr_rst;
    logic [22:0] w_addr_step;

    // Rising edge of the synchronized request: acts on the third clk edge
    // after get_new_address rises.
    assign w_adv      = r_gna_sync & ~r_gna_prev;
    assign w_rst_any  = restart | r_rst_pend;
    assign w_addr_rst = count_up ? START_ADDR : END_ADDR;
    assign w_addr_step = count_up
        ? ((r_addr == END_ADDR)   ? START_ADDR : r_addr + 23'd1)
        : ((r_addr == START_ADDR) ? END_ADDR   : r_addr - 23'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gna_meta <= 1'b0;
            r_gna_sync <= 1'b0;
            r_gna_prev <= 1'b0;
        end else begin
            r_gna_meta <= get_new_address;
            r_gna_sync <= r_gna_meta;
            r_gna_prev <= r_gna_sync;
        end
    end

    // r_rst_pend records a restart seen mid-transaction. Once the transaction
    // completes into HOLD the address has already been reloaded, and the flag
    // then only means "go fetch the restarted address".
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= START_ADDR;
            r_read     <= 1'b0;
            r_ren      <= 1'b0;
            r_rst_pend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ren <= 1'b0;
                    if (restart) begin
                        r_addr <= w_addr_rst;
                    end
                    if (start) begin
                        r_state <= ISSUE;
                        r_read  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (restart) begin
                        r_rst_pend <= 1'b1;
                    end
                    if (!flash_mem_waitrequest) begin
                        r_state <= WAIT_VALID;
                        r_read  <= 1'b0;
                    end
                end
                WAIT_VALID: begin
                    if (restart) begin
                        r_rst_pend <= 1'b1;
                    end
                    if (flash_mem_readdatavalid) begin
                        if (w_rst_any) begin
                            r_addr <= w_addr_rst;
                        end
                        if (start) begin
                            r_state    <= HOLD;
                            r_ren      <= 1'b1;
                            r_rst_pend <= w_rst_any;
                        end else begin
                            r_state    <= IDLE;
                            r_ren      <= 1'b0;
                            r_rst_pend <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    // restart beats a simultaneous advance, which is dropped
                    if (restart) begin
                        r_addr     <= w_addr_rst;
                        r_rst_pend <= 1'b0;
                        if (start) begin
                            r_state <= ISSUE;
                            r_read  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_ren   <= 1'b0;
                        end
                    end else if (!start) begin
                        r_state    <= IDLE;
                        r_ren      <= 1'b0;
                        r_rst_pend <= 1'b0;
                    end else if (r_rst_pend) begin
                        r_state    <= ISSUE;
                        r_read     <= 1'b1;
                        r_rst_pend <= 1'b0;
                    end else if (w_adv) begin
                        r_addr  <= w_addr_step;
                        r_state <= ISSUE;
                        r_read  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_read  <= 1'b0;
                    r_ren   <= 1'b0;
                end
            endcase
        end
    end

    assign flash_mem_read       = r_read;
    assign flash_mem_address    = r_addr;
    assign flash_mem_byteenable = 4'hF;
    assign read_flash_en        = r_ren;

endmodule

// File: tb/tb_flash_addr_ctrl.sv
module tb_flash_addr_ctrl;

    localparam logic [22:0] START = 23'h000000;
    localparam logic [22:0] ENDA  = 23'h07FFFF;
    localparam int          NREG  = int'(ENDA) - int'(START) + 1;

    logic        clk;
    logic        reset;
    logic        start;
    logic        restart;
    logic        count_up;
    logic        get_new_address;
    logic        flash_mem_waitrequest;
    logic        flash_mem_readdatavalid;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic        read_flash_en;

    int          n_tests;
    int          n_fail;
    logic [22:0] m_addr;

    flash_addr_ctrl #(
        .START_ADDR (START),
        .END_ADDR   (ENDA)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .restart                 (restart),
        .count_up                (count_up),
        .get_new_address         (get_new_address),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .read_flash_en           (read_flash_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Region walk as plain modular arithmetic on the offset into the region.
    function automatic logic [22:0] model_next(input logic [22:0] a, input bit up);
        int off;
        off = int'(a) - int'(START);
        off = up ? (off + 1) % NREG : (off + NREG - 1) % NREG;
        return 23'(off + int'(START));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered with the DUT just having raised its read strobe. Serves one read:
    // n_wait cycles of waitrequest, then n_lat idle cycles before readdatavalid.
    task automatic run_read(input int n_wait, input int n_lat, input int rst_at,
                            input bit adv_in_issue, input bit drop_start);
        int   cnt;
        bit   stable;
        logic ren0;
        ren0 = read_flash_en;
        chk("rd_strobe", 32'(flash_mem_read), 32'd1);
        chk("rd_addr", 32'(flash_mem_address), 32'(m_addr));
        cnt    = 0;
        stable = 1'b1;
        while (flash_mem_read === 1'b1 && cnt < 40) begin
            cnt++;
            flash_mem_waitrequest   = (cnt <= n_wait);
            flash_mem_readdatavalid = 1'($urandom_range(0, 1));
            restart                 = (cnt == rst_at);
            if (adv_in_issue) get_new_address = (cnt <= 2);
            tick();
            if (flash_mem_address !== m_addr || read_flash_en !== ren0) stable = 1'b0;
        end
        restart                 = 1'b0;
        get_new_address         = 1'b0;
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        chk("rd_len", 32'(cnt), 32'(n_wait + 1));
        if (drop_start) start = 1'b0;
        for (int k = 0; k < n_lat; k++) begin
            tick();
            if (flash_mem_read !== 1'b0 || read_flash_en !== ren0 ||
                flash_mem_address !== m_addr) stable = 1'b0;
        end
        chk("rd_stable", 32'(stable), 32'd1);
        flash_mem_readdatavalid = 1'b1;
        tick();
        flash_mem_readdatavalid = 1'b0;
        if (rst_at != 0) m_addr = count_up ? START : ENDA;
        chk("ren_after_valid", 32'(read_flash_en), drop_start ? 32'd0 : 32'd1);
        chk("addr_after_valid", 32'(flash_mem_address), 32'(m_addr));
        chk("read_after_valid", 32'(flash_mem_read), 32'd0);
    endtask

    task automatic hold(input int n);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            flash_mem_readdatavalid = 1'($urandom_range(0, 1));
            tick();
            if (flash_mem_read !== 1'b0 || read_flash_en !== 1'b1 ||
                flash_mem_address !== m_addr) ok = 1'b0;
        end
        flash_mem_readdatavalid = 1'b0;
        if (n > 0) chk("hold_steady", 32'(ok), 32'd1);
    endtask

    // Advance from HOLD: the address must move on the third edge, not before.
    task automatic advance(input bit up);
        bit ok;
        count_up        = up;
        get_new_address = 1'b1;
        ok              = 1'b1;
        tick();
        if (flash_mem_address !== m_addr || flash_mem_read !== 1'b0) ok = 1'b0;
        tick();
        if (flash_mem_address !== m_addr || flash_mem_read !== 1'b0) ok = 1'b0;
        get_new_address = 1'b0;
        tick();
        chk("adv_latency", 32'(ok), 32'd1);
        m_addr = model_next(m_addr, up);
        chk("adv_addr", 32'(flash_mem_address), 32'(m_addr));
        chk("adv_read", 32'(flash_mem_read), 32'd1);
    endtask

    initial begin
        int nw;
        int nl;
        int ra;
        bit ok;
        n_tests                 = 0;
        n_fail                  = 0;
        reset                   = 1'b1;
        start                   = 1'b0;
        restart                 = 1'b0;
        count_up                = 1'b1;
        get_new_address         = 1'b0;
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        m_addr                  = START;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_read", 32'(flash_mem_read), 32'd0);
        chk("rst_ren", 32'(read_flash_en), 32'd0);
        chk("rst_addr", 32'(flash_mem_address), 32'(START));
        chk("rst_byteen", 32'(flash_mem_byteenable), 32'hF);

        // first read: 3 waitrequest cycles, valid 2 cycles later
        start                 = 1'b1;
        flash_mem_waitrequest = 1'b1;
        tick();
        run_read(3, 2, 0, 1'b0, 1'b0);
        hold(3);

        // wrap downwards, then upwards across the region ends
        advance(1'b0);
        chk("wrap_down", 32'(flash_mem_address), 32'h07FFFF);
        run_read(1, 1, 0, 1'b0, 1'b0);
        hold(2);
        advance(1'b1);
        chk("wrap_up", 32'(flash_mem_address), 32'h000000);
        run_read(0, 0, 0, 1'b0, 1'b0);
        advance(1'b1);
        run_read(2, 1, 0, 1'b0, 1'b0);
        advance(1'b1);
        run_read(1, 0, 0, 1'b0, 1'b0);
        advance(1'b1);

        // restart during waitrequest: address held, then restarted and refetched
        run_read(3, 1, 2, 1'b0, 1'b0);
        chk("restart_pend_addr", 32'(flash_mem_address), 32'h000000);
        tick();
        run_read(0, 1, 0, 1'b0, 1'b0);

        // advance edge landing in ISSUE is dropped
        advance(1'b1);
        run_read(4, 1, 0, 1'b1, 1'b0);
        hold(6);

        // restart and advance in the same cycle: restart wins
        count_up        = 1'b0;
        get_new_address = 1'b1;
        tick();
        tick();
        get_new_address = 1'b0;
        restart         = 1'b1;
        tick();
        restart = 1'b0;
        m_addr  = ENDA;
        chk("rst_vs_adv_addr", 32'(flash_mem_address), 32'(ENDA));
        chk("rst_vs_adv_read", 32'(flash_mem_read), 32'd1);
        run_read(1, 0, 0, 1'b0, 1'b0);
        hold(4);

        // stop while waiting for valid: completes, pauses, keeps address
        advance(1'b0);
        run_read(1, 2, 0, 1'b0, 1'b1);
        get_new_address = 1'b1;
        tick();
        tick();
        get_new_address = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (flash_mem_read !== 1'b0 || read_flash_en !== 1'b0 ||
                flash_mem_address !== m_addr) ok = 1'b0;
        end
        chk("pause_steady", 32'(ok), 32'd1);

        // restart while paused, count_up=0
        count_up = 1'b0;
        restart  = 1'b1;
        tick();
        restart = 1'b0;
        m_addr  = ENDA;
        chk("idle_restart_addr", 32'(flash_mem_address), 32'(ENDA));
        chk("idle_restart_read", 32'(flash_mem_read), 32'd0);
        start = 1'b1;
        tick();
        run_read(0, 1, 0, 1'b0, 1'b0);
        advance(1'b1);
        chk("resume_wrap", 32'(flash_mem_address), 32'h000000);
        run_read(1, 1, 0, 1'b0, 1'b0);

        // randomized walk against the model
        for (int it = 0; it < 30; it++) begin
            hold($urandom_range(0, 3));
            advance(1'($urandom_range(0, 1)));
            nw = $urandom_range(0, 3);
            nl = $urandom_range(0, 3);
            ra = ($urandom_range(0, 4) == 0) ? 1 : 0;
            run_read(nw, nl, ra, 1'b0, 1'b0);
            if (ra != 0) begin
                tick();
                run_read($urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, 1'b0);
            end
        end

        // reset in the middle of a read
        advance(1'b1);
        flash_mem_waitrequest = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        start  = 1'b0;
        m_addr = START;
        chk("midrst_read", 32'(flash_mem_read), 32'd0);
        chk("midrst_addr", 32'(flash_mem_address), 32'(START));
        chk("midrst_ren", 32'(read_flash_en), 32'd0);
        tick();
        chk("midrst_idle", 32'(flash_mem_read), 32'd0);
        start = 1'b1;
        tick();
        run_read(0, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
